// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: bulls-and-cows round sequencer (secret load, guess capture, scoring, win/lose).
module guess_round_ctrl #(
  parameter int MAX_GUESS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  iNum1,
  input  logic [3:0]  iNum2,
  input  logic [3:0]  iNum3,
  input  logic        iNumRdy,
  output logic [11:0] oAns,
  output logic [11:0] oGuess,
  output logic [1:0]  oA,
  output logic [1:0]  oB,
  output logic [3:0]  oGuessCnt,
  output logic [2:0]  oState,
  output logic        oPlayOn,
  output logic        oWin,
  output logic        oLose,
  output logic        oScoreVld,
  output logic        oReject
);
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, SCORE = 3'd2, WIN = 3'd3, LOSE = 3'd4} state_t;
  state_t state_q, state_d;
  logic rdy_q;
  logic [11:0] ans_q, ans_d, guess_q, guess_d;
  logic [1:0] a_q, a_d, b_q, b_d, a_sc, b_sc;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic vld_q, vld_d, rej_q, rej_d;
  logic rise, valid;
  logic [3:0] g1, g2, g3, d1, d2, d3;
  assign rise  = iNumRdy & ~rdy_q;
  assign valid = (iNum1 <= 4'd9) & (iNum2 <= 4'd9) & (iNum3 <= 4'd9) &
                 (iNum1 != iNum2) & (iNum1 != iNum3) & (iNum2 != iNum3);
  assign {g1, g2, g3} = guess_q;
  assign {d1, d2, d3} = ans_q;
  // Distinct digits bound a+b to 3, so 2-bit sums cannot wrap.
  assign a_sc = 2'(g1 == d1) + 2'(g2 == d2) + 2'(g3 == d3);
  assign b_sc = 2'(g1 == d2) + 2'(g1 == d3) + 2'(g2 == d1) +
                2'(g2 == d3) + 2'(g3 == d1) + 2'(g3 == d2);
  assign cnt_inc = cnt_q + 4'd1;
  always_comb begin
    state_d = state_q;
    ans_d   = ans_q;
    guess_d = guess_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    rej_d   = 1'b0;
    if (state_q == SCORE) begin
      a_d     = a_sc;
      b_d     = b_sc;
      cnt_d   = cnt_inc;
      vld_d   = 1'b1;
      state_d = (a_sc == 2'd3) ? WIN : (cnt_inc == 4'(MAX_GUESS)) ? LOSE : PLAY;
    end else if (rise && !valid) begin
      rej_d = 1'b1;
    end else if (rise && state_q == PLAY) begin
      guess_d = {iNum1, iNum2, iNum3};
      state_d = SCORE;
    end else if (rise) begin
      ans_d   = {iNum1, iNum2, iNum3};
      guess_d = '0;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      state_d = PLAY;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      ans_q   <= '0;
      guess_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= iNumRdy;
      ans_q   <= ans_d;
      guess_q <= guess_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      rej_q   <= rej_d;
    end
  end
  assign oAns      = ans_q;
  assign oGuess    = guess_q;
  assign oA        = a_q;
  assign oB        = b_q;
  assign oGuessCnt = cnt_q;
  assign oState    = state_q;
  assign oPlayOn   = state_q != IDLE;
  assign oWin      = state_q == WIN;
  assign oLose     = state_q == LOSE;
  assign oScoreVld = vld_q;
  assign oReject   = rej_q;
endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb_guess_round_ctrl: table-driven cycle-by-cycle check of guess_round_ctrl with MAX_GUESS=3.
module tb_guess_round_ctrl;
  logic clk = 1'b0, reset = 1'b1, iNumRdy = 1'b0;
  logic [3:0] iNum1 = '0, iNum2 = '0, iNum3 = '0;
  logic [11:0] oAns, oGuess;
  logic [1:0] oA, oB;
  logic [3:0] oGuessCnt;
  logic [2:0] oState;
  logic oPlayOn, oWin, oLose, oScoreVld, oReject;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  guess_round_ctrl #(.MAX_GUESS(3)) dut (
    .clk(clk), .reset(reset), .iNum1(iNum1), .iNum2(iNum2), .iNum3(iNum3), .iNumRdy(iNumRdy),
    .oAns(oAns), .oGuess(oGuess), .oA(oA), .oB(oB), .oGuessCnt(oGuessCnt), .oState(oState),
    .oPlayOn(oPlayOn), .oWin(oWin), .oLose(oLose), .oScoreVld(oScoreVld), .oReject(oReject)
  );
  typedef struct {
    logic rst, rdy;
    logic [11:0] num;
    logic [2:0] st;
    logic [11:0] ans, gs;
    logic [1:0] a, b;
    logic [3:0] cnt;
    logic vld, rej;
  } vec_t;
  function automatic vec_t mk(input logic rst, rdy, input logic [11:0] num, input logic [2:0] st,
                              input logic [11:0] ans, gs, input logic [1:0] a, b,
                              input logic [3:0] cnt, input logic vld, rej);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.num = num; v.st = st; v.ans = ans; v.gs = gs;
    v.a = a; v.b = b; v.cnt = cnt; v.vld = vld; v.rej = rej;
    return v;
  endfunction
  // Drive one cycle of inputs, then compare every output just after the edge.
  task automatic apply(input string name, input vec_t v);
    logic [39:0] act, exp;
    reset = v.rst;
    iNumRdy = v.rdy;
    {iNum1, iNum2, iNum3} = v.num;
    @(posedge clk);
    #1;
    act = {oState, oAns, oGuess, oA, oB, oGuessCnt, oPlayOn, oWin, oLose, oScoreVld, oReject};
    exp = {v.st, v.ans, v.gs, v.a, v.b, v.cnt, v.st != 3'd0, v.st == 3'd3, v.st == 3'd4, v.vld, v.rej};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d ans=%h gs=%h a=%0d b=%0d cnt=%0d pwl=%b%b%b vld=%b rej=%b, expected %h (act %h)",
               name, oState, oAns, oGuess, oA, oB, oGuessCnt, oPlayOn, oWin, oLose, oScoreVld, oReject, exp, act);
    end
  endtask
  vec_t tbl[$];
  initial begin
    //            rst  rdy  num     st ans     guess   a b cnt vld rej
    tbl.push_back(mk(1, 0, 12'h000, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0)); // reset
    tbl.push_back(mk(0, 1, 12'h123, 1, 12'h123, 12'h000, 0, 0, 0, 0, 0)); // load secret
    tbl.push_back(mk(0, 0, 12'h123, 1, 12'h123, 12'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'h132, 2, 12'h123, 12'h132, 0, 0, 0, 0, 0)); // guess 132
    tbl.push_back(mk(0, 0, 12'h132, 1, 12'h123, 12'h132, 1, 2, 1, 1, 0)); // 1A2B
    tbl.push_back(mk(0, 0, 12'h132, 1, 12'h123, 12'h132, 1, 2, 1, 0, 0)); // pulse ends
    tbl.push_back(mk(0, 1, 12'h112, 1, 12'h123, 12'h132, 1, 2, 1, 0, 1)); // dup digit
    tbl.push_back(mk(0, 0, 12'h112, 1, 12'h123, 12'h132, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 12'h1A3, 1, 12'h123, 12'h132, 1, 2, 1, 0, 1)); // non-BCD
    tbl.push_back(mk(0, 0, 12'h1A3, 1, 12'h123, 12'h132, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 12'h456, 2, 12'h123, 12'h456, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 12'h456, 1, 12'h123, 12'h456, 0, 0, 2, 1, 0)); // 0A0B
    tbl.push_back(mk(0, 1, 12'h123, 2, 12'h123, 12'h123, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 12'h123, 3, 12'h123, 12'h123, 3, 0, 3, 1, 0)); // win beats lose
    tbl.push_back(mk(0, 0, 12'h123, 3, 12'h123, 12'h123, 3, 0, 3, 0, 0));
    tbl.push_back(mk(0, 1, 12'h122, 3, 12'h123, 12'h123, 3, 0, 3, 0, 1)); // reject in WIN
    tbl.push_back(mk(0, 0, 12'h122, 3, 12'h123, 12'h123, 3, 0, 3, 0, 0));
    tbl.push_back(mk(0, 1, 12'h987, 1, 12'h987, 12'h000, 0, 0, 0, 0, 0)); // restart from WIN
    tbl.push_back(mk(0, 0, 12'h987, 1, 12'h987, 12'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'h123, 2, 12'h987, 12'h123, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 12'h123, 1, 12'h987, 12'h123, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 12'h456, 2, 12'h987, 12'h456, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 12'h456, 1, 12'h987, 12'h456, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 12'h012, 2, 12'h987, 12'h012, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 12'h012, 4, 12'h987, 12'h012, 0, 0, 3, 1, 0)); // lose
    tbl.push_back(mk(0, 1, 12'h456, 1, 12'h456, 12'h000, 0, 0, 0, 0, 0)); // restart from LOSE
    tbl.push_back(mk(0, 0, 12'h456, 1, 12'h456, 12'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 12'h465, 2, 12'h456, 12'h465, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 12'h465, 1, 12'h456, 12'h465, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 12'h457, 2, 12'h456, 12'h457, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 12'h457, 1, 12'h456, 12'h457, 2, 0, 2, 1, 0)); // 2A0B
    tbl.push_back(mk(0, 1, 12'h564, 2, 12'h456, 12'h564, 2, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 12'h564, 4, 12'h456, 12'h564, 0, 3, 3, 1, 0)); // 0A3B, lose
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);
    // Reset during the SCORE cycle commits nothing.
    apply("mid_load",  mk(0, 1, 12'h123, 1, 12'h123, 12'h000, 0, 0, 0, 0, 0));
    apply("mid_idle",  mk(0, 0, 12'h123, 1, 12'h123, 12'h000, 0, 0, 0, 0, 0));
    apply("mid_guess", mk(0, 1, 12'h321, 2, 12'h123, 12'h321, 0, 0, 0, 0, 0));
    apply("mid_reset", mk(1, 0, 12'h321, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0));
    // Level held through reset: reset wins, then exactly one load.
    apply("hold_rst",  mk(1, 1, 12'h123, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0));
    apply("hold_load", mk(0, 1, 12'h123, 1, 12'h123, 12'h000, 0, 0, 0, 0, 0));
    apply("hold_lvl1", mk(0, 1, 12'h123, 1, 12'h123, 12'h000, 0, 0, 0, 0, 0));
    apply("hold_lvl2", mk(0, 1, 12'h456, 1, 12'h123, 12'h000, 0, 0, 0, 0, 0));
    apply("hold_low",  mk(0, 0, 12'h456, 1, 12'h123, 12'h000, 0, 0, 0, 0, 0));
    // Held-high invalid level in PLAY rejects only once.
    apply("rej_once",  mk(0, 1, 12'h999, 1, 12'h123, 12'h000, 0, 0, 0, 0, 1));
    apply("rej_hold",  mk(0, 1, 12'h999, 1, 12'h123, 12'h000, 0, 0, 0, 0, 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/guess_round_ctrl.md
# guess_round_ctrl

Round sequencer for the three-digit bulls-and-cows (xAyB) game. It sits between the keypad digit capture (iNum1..3 / iNumRdy) and the VGA text overlay. It captures and validates the secret, accepts guesses, and scores each guess in a dedicated cycle. It also counts attempts and holds win/lose status for the overlay to render. It replaces ad-hoc flag/latch logic with one explicit FSM.

## Interface
- MAX_GUESS, 10, attempts allowed per round; legal range 1..15
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- iNum1  in  4  digit 1 (leftmost), BCD
- iNum2  in  4  digit 2, BCD
- iNum3  in  4  digit 3 (rightmost), BCD
- iNumRdy  in  1  digit-entry ready, level; the block acts on its rising edge only
- oAns  out  12  latched secret {d1,d2,d3}
- oGuess  out  12  last accepted guess {g1,g2,g3}
- oA  out  2  exact-position matches of last scored guess
- oB  out  2  right-digit, wrong-position matches of last scored guess
- oGuessCnt  out  4  guesses scored this round
- oState  out  3  FSM state: IDLE=0, PLAY=1, SCORE=2, WIN=3, LOSE=4
- oPlayOn  out  1  high whenever state != IDLE
- oWin  out  1  high in WIN
- oLose  out  1  high in LOSE
- oScoreVld  out  1  one-cycle pulse when oA/oB/oGuessCnt update
- oReject  out  1  one-cycle pulse when an entry is rejected as invalid

## Operation
- Edge detect: register rdy_d <= iNumRdy. rise = iNumRdy & ~rdy_d. rdy_d resets to 0, so a level held high through reset counts as a rise on the first cycle after reset.
- Valid entry: every digit <= 9 and all three digits pairwise distinct.
- Invalid entry on a rise in IDLE, PLAY, WIN or LOSE: oReject pulses; no register or state changes.
- IDLE: valid rise -> latch iNum1..3 into oAns; clear oGuessCnt, oA, oB and oGuess; go to PLAY.
- PLAY: valid rise -> latch the digits into oGuess; go to SCORE.
- SCORE (exactly one cycle):
  - oA = count of positions i where g_i == d_i.
  - oB = count of pairs i != j where g_i == d_j. Distinct digits guarantee oA + oB <= 3, so both fit in 2 bits.
  - oGuessCnt increments by 1 and oScoreVld pulses.
  - Next state: WIN if the new oA == 3; else LOSE if the new oGuessCnt == MAX_GUESS; else PLAY. WIN takes priority when both hold.
- A rise in SCORE is dropped silently: no reject pulse, no latch.
- WIN / LOSE: all outputs hold. A valid rise starts a new round: the entry becomes the new secret, oGuessCnt/oA/oB/oGuess clear, and the FSM goes to PLAY.
- oGuessCnt never exceeds MAX_GUESS, because LOSE is entered on reaching it.

## Timing
- Reset values: state IDLE, oState=0, and every output 0 (oAns, oGuess, oA, oB, oGuessCnt, oPlayOn, oWin, oLose, oScoreVld, oReject).
- All outputs are registered; there are no combinational input-to-output paths.
- A rise is detected in cycle N when iNumRdy=1 and rdy_d=0. Its effects (state, oAns/oGuess, oReject) are visible in cycle N+1.
- Guess latency: rise in cycle N -> SCORE in N+1 -> oA, oB, oGuessCnt, oScoreVld and the next state (PLAY/WIN/LOSE) all visible in N+2.
- Earliest next accepted guess: a rise detected in cycle N+2.
- reset asserted in any state, including SCORE, returns the block to reset values on the next edge. No partial score is committed.
- When reset and a rise occur in the same cycle, reset wins.

## Test plan
- Secret load: reset, then pulse iNumRdy with {1,2,3} -> oState=1, oAns=12'h123, oPlayOn=1, oGuessCnt=0.
- Scoring: secret 123, guess {1,3,2} -> oGuess=12'h132; two cycles after the rise oA=1, oB=2, oGuessCnt=1, oScoreVld high for 1 cycle, oState=1.
- Win: secret 123, guess {4,5,6} (oA=0, oB=0), then guess {1,2,3} -> oA=3, oWin=1, oState=3, oGuessCnt=2.
- Rejects: in PLAY, enter {1,1,2}, then {1,10,3} -> oReject pulses once per entry; oGuess, oGuessCnt and oState are unchanged.
- Lose and restart (MAX_GUESS=3): secret 987, guesses 123/456/012 -> oLose=1, oGuessCnt=3. Then enter {4,5,6} -> oState=1, oAns=12'h456, oGuessCnt=0.
- Reset mid-score and held level: assert reset in the SCORE cycle -> all outputs 0 next cycle. Hold iNumRdy high with 123 through reset release -> a single load of 123, with no repeat while the level stays high.
